// File: rtl/envelope_pkg.sv
// Shared stage codes and sizing helper for the ADSR shift envelope.
package envelope_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } stage_t;

  // Largest attenuation shift representable in a w-bit field (silent level).
  function automatic int max_shift(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/env_rate_tick.sv
// Loadable down-counter: tick pulses once per latched period and reloads itself.
module env_rate_tick #(
  parameter int CNT_W       = 32,
  parameter int STEP_CYCLES = 50000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] period_q;

  assign tick = (count_q == '0);

  // Loading with period-1 puts the first tick exactly one period after the load edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      period_q <= CNT_W'(STEP_CYCLES);
    end else if (load) begin
      count_q  <= period - CNT_W'(1);
      period_q <= period;
    end else if (tick) begin
      count_q  <= period_q - CNT_W'(1);
    end else begin
      count_q  <= count_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/adsr_shift_envelope.sv
// ADSR envelope expressed as a right-shift attenuation (0 = full level, MAX = silent).
// Valid/ready does not apply: gate is a level input sampled every clock.
module adsr_shift_envelope
  import envelope_pkg::*;
#(
  parameter int SHIFT_W     = 4,
  parameter int VAL_W       = 4,
  parameter int STEP_CYCLES = 50000,
  parameter int CNT_W       = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               gate,
  input  logic [VAL_W-1:0]   attack_value,
  input  logic [VAL_W-1:0]   decay_value,
  input  logic [SHIFT_W-1:0] sustain_value,
  input  logic [VAL_W-1:0]   release_value,
  output logic [SHIFT_W-1:0] shift_amount,
  output logic [2:0]         stage,
  output logic               busy,
  output logic               done
);

  localparam logic [SHIFT_W-1:0] MAX_SHIFT = SHIFT_W'(max_shift(SHIFT_W));
  localparam logic [SHIFT_W-1:0] ONE       = SHIFT_W'(1);

  stage_t             state_q, state_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [SHIFT_W-1:0] sus_shift;
  logic               done_q, done_d;
  logic               tick, load;
  logic [VAL_W-1:0]   code;
  logic [CNT_W-1:0]   period;

  assign sus_shift = MAX_SHIFT - sustain_value;

  // The step is applied before any transition, so a gate change on a step cycle keeps the step.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gate) state_d = ST_ATTACK;
      end
      ST_ATTACK: begin
        if (tick && shift_q != '0) shift_d = shift_q - ONE;
        if (!gate)                 state_d = ST_RELEASE;
        else if (shift_d == '0)    state_d = (sus_shift == '0) ? ST_SUSTAIN : ST_DECAY;
      end
      ST_DECAY: begin
        if (tick && shift_q != MAX_SHIFT) shift_d = shift_q + ONE;
        if (!gate)                        state_d = ST_RELEASE;
        else if (shift_d >= sus_shift)    state_d = ST_SUSTAIN;
      end
      ST_SUSTAIN: begin
        if (!gate) state_d = ST_RELEASE;
        else       shift_d = sus_shift;
      end
      ST_RELEASE: begin
        if (tick && shift_q != MAX_SHIFT) shift_d = shift_q + ONE;
        if (gate) begin
          state_d = ST_ATTACK;
        end else if (shift_d == MAX_SHIFT) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Rate code of the stage being entered; latched by the tick counter on the entry edge.
  always_comb begin
    code = '0;
    case (state_d)
      ST_ATTACK:  code = attack_value;
      ST_DECAY:   code = decay_value;
      ST_RELEASE: code = release_value;
      default:    code = '0;
    endcase
  end

  assign period = (CNT_W'(code) + CNT_W'(1)) * CNT_W'(STEP_CYCLES);
  assign load   = (state_d != state_q);

  env_rate_tick #(
    .CNT_W       (CNT_W),
    .STEP_CYCLES (STEP_CYCLES)
  ) u_rate_tick (
    .clock  (clock),
    .reset  (reset),
    .load   (load),
    .period (period),
    .tick   (tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shift_q <= MAX_SHIFT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      done_q  <= done_d;
    end
  end

  assign shift_amount = shift_q;
  assign stage        = state_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;

endmodule

// File: tb/tb_adsr_shift_envelope.sv
// Randomised and directed bench for adsr_shift_envelope against a step-counting reference model.
module tb_adsr_shift_envelope;

  localparam int SHIFT_W = 4;
  localparam int VAL_W   = 4;
  localparam int SC      = 2;
  localparam int CNT_W   = 32;
  localparam int MAXS    = 15;

  logic               clock;
  logic               reset;
  logic               gate;
  logic [VAL_W-1:0]   attack_value;
  logic [VAL_W-1:0]   decay_value;
  logic [SHIFT_W-1:0] sustain_value;
  logic [VAL_W-1:0]   release_value;
  logic [SHIFT_W-1:0] shift_amount;
  logic [2:0]         stage;
  logic               busy;
  logic               done;

  int vectors;
  int miscompares;

  // Reference model: stage as 0..4, level as int, cycles since entry and step period.
  int m_stage, m_shift, m_age, m_per;
  bit m_done;

  adsr_shift_envelope #(
    .SHIFT_W     (SHIFT_W),
    .VAL_W       (VAL_W),
    .STEP_CYCLES (SC),
    .CNT_W       (CNT_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .gate          (gate),
    .attack_value  (attack_value),
    .decay_value   (decay_value),
    .sustain_value (sustain_value),
    .release_value (release_value),
    .shift_amount  (shift_amount),
    .stage         (stage),
    .busy          (busy),
    .done          (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_reset();
    m_stage = 0; m_shift = MAXS; m_age = 0; m_per = SC; m_done = 0;
  endtask

  function automatic int rate_of(input int s);
    case (s)
      1:       return (int'(attack_value) + 1) * SC;
      2:       return (int'(decay_value) + 1) * SC;
      4:       return (int'(release_value) + 1) * SC;
      default: return SC;
    endcase
  endfunction

  // One clock edge of the envelope: a step lands whenever a whole period has elapsed since entry.
  task automatic model_step();
    int sus, nst, sh;
    bit stp;
    sus = MAXS - int'(sustain_value);
    stp = ((m_age + 1) % m_per) == 0;
    nst = m_stage; sh = m_shift; m_done = 0;
    case (m_stage)
      0: if (gate) nst = 1;
      1: begin
        if (stp) sh = (sh > 0) ? sh - 1 : 0;
        if (!gate) nst = 4; else if (sh == 0) nst = (sus == 0) ? 3 : 2;
      end
      2: begin
        if (stp) sh = (sh < MAXS) ? sh + 1 : MAXS;
        if (!gate) nst = 4; else if (sh >= sus) nst = 3;
      end
      3: if (!gate) nst = 4; else sh = sus;
      default: begin
        if (stp) sh = (sh < MAXS) ? sh + 1 : MAXS;
        if (gate) nst = 1;
        else if (sh == MAXS) begin nst = 0; m_done = 1; end
      end
    endcase
    if (nst != m_stage) begin m_age = 0; m_per = rate_of(nst); end
    else m_age++;
    m_stage = nst; m_shift = sh;
  endtask

  task automatic cyc();
    @(posedge clock);
    if (reset) model_reset(); else model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; gate = 1'b0;
    attack_value = '0; decay_value = '0; sustain_value = '0; release_value = '0;
    model_reset();
    cyc(); cyc();
    vectors++;
    if (shift_amount !== 4'd15 || stage !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values got shift=%0d stage=%0d busy=%0b done=%0b want 15/0/0/0",
               shift_amount, stage, busy, done);
    end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_adsr();
    int att, dec, sus;
    att = 0; dec = 0; sus = 0;
    attack_value = 4'd0; decay_value = 4'd1; sustain_value = 4'd12; release_value = 4'd0;
    gate = 1'b1;
    for (int i = 0; i < 150 && sus < 10; i++) begin
      cyc();
      vectors++;
      if (shift_amount !== 4'(m_shift) || stage !== 3'(m_stage) || busy !== (m_stage != 0) || done !== m_done) begin
        miscompares++;
        $display("FAIL adsr_track t=%0t got %0d/%0d/%0b/%0b want %0d/%0d/%0b", $time,
                 shift_amount, stage, busy, done, m_shift, m_stage, m_done);
      end
      if (stage == 3'd1) att++;
      if (stage == 3'd2) dec++;
      if (stage == 3'd3) sus++;
    end
    vectors++;
    if (att != 30) begin miscompares++; $display("FAIL attack_cycles got %0d want 30", att); end
    vectors++;
    if (dec != 12) begin miscompares++; $display("FAIL decay_cycles got %0d want 12", dec); end
    vectors++;
    if (sus != 10 || shift_amount !== 4'd3) begin
      miscompares++;
      $display("FAIL sustain_hold got sus_cycles=%0d shift=%0d want 10/3", sus, shift_amount);
    end
  endtask

  task automatic test_release();
    int rel, dn;
    bit idle_seen;
    rel = 0; dn = 0; idle_seen = 0;
    gate = 1'b0;
    for (int i = 0; i < 100 && !idle_seen; i++) begin
      cyc();
      vectors++;
      if (shift_amount !== 4'(m_shift) || stage !== 3'(m_stage) || busy !== (m_stage != 0) || done !== m_done) begin
        miscompares++;
        $display("FAIL release_track t=%0t got %0d/%0d/%0b/%0b want %0d/%0d/%0b", $time,
                 shift_amount, stage, busy, done, m_shift, m_stage, m_done);
      end
      if (stage == 3'd4) rel++;
      if (done) dn++;
      if (stage == 3'd0) idle_seen = 1;
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (done) dn++;
    end
    vectors++;
    if (rel != 24) begin miscompares++; $display("FAIL release_cycles got %0d want 24", rel); end
    vectors++;
    if (dn != 1) begin miscompares++; $display("FAIL done_pulses got %0d want 1", dn); end
    vectors++;
    if (shift_amount !== 4'd15 || stage !== 3'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL release_end got shift=%0d stage=%0d busy=%0b want 15/0/0", shift_amount, stage, busy);
    end
  endtask

  task automatic test_retrigger();
    int dn, guard;
    dn = 0;
    attack_value = 4'd0; decay_value = 4'd1; sustain_value = 4'd12; release_value = 4'd0;
    gate = 1'b1;
    guard = 0;
    while (!(stage == 3'd1 && shift_amount == 4'd9) && guard < 80) begin
      cyc(); guard++;
      vectors++;
      if (shift_amount !== 4'(m_shift) || stage !== 3'(m_stage) || done !== m_done) begin
        miscompares++;
        $display("FAIL retrig_attack t=%0t got %0d/%0d/%0b want %0d/%0d/%0b", $time,
                 shift_amount, stage, done, m_shift, m_stage, m_done);
      end
    end
    gate = 1'b0;
    guard = 0;
    while (!(stage == 3'd4 && shift_amount == 4'd12) && guard < 80) begin
      cyc(); guard++;
      if (done) dn++;
      vectors++;
      if (shift_amount !== 4'(m_shift) || stage !== 3'(m_stage) || done !== m_done) begin
        miscompares++;
        $display("FAIL retrig_release t=%0t got %0d/%0d/%0b want %0d/%0d/%0b", $time,
                 shift_amount, stage, done, m_shift, m_stage, m_done);
      end
    end
    gate = 1'b1;
    cyc();
    vectors++;
    if (stage !== 3'd1 || shift_amount !== 4'd12) begin
      miscompares++;
      $display("FAIL retrig_entry got stage=%0d shift=%0d want 1/12", stage, shift_amount);
    end
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (done) dn++;
    end
    vectors++;
    if (dn != 0) begin miscompares++; $display("FAIL retrig_no_done got %0d want 0", dn); end
    gate = 1'b0;
    for (int i = 0; i < 60 && stage != 3'd0; i++) cyc();
  endtask

  task automatic test_sustain_extremes();
    int dec;
    bit reached;
    dec = 0; reached = 0;
    sustain_value = 4'd15; attack_value = 4'd0; release_value = 4'd0;
    gate = 1'b1;
    for (int i = 0; i < 100 && !reached; i++) begin
      cyc();
      if (stage == 3'd2) dec++;
      if (stage == 3'd3) reached = 1;
    end
    vectors++;
    if (!reached || dec != 0 || shift_amount !== 4'd0) begin
      miscompares++;
      $display("FAIL sustain_full got reached=%0b decay_cycles=%0d shift=%0d want 1/0/0", reached, dec, shift_amount);
    end
    gate = 1'b0;
    for (int i = 0; i < 60 && stage != 3'd0; i++) cyc();
    sustain_value = 4'd0; decay_value = 4'd0;
    gate = 1'b1;
    for (int i = 0; i < 120; i++) begin
      cyc();
      vectors++;
      if (shift_amount !== 4'(m_shift) || stage !== 3'(m_stage) || busy !== (m_stage != 0) || done !== m_done) begin
        miscompares++;
        $display("FAIL silent_track t=%0t got %0d/%0d/%0b/%0b want %0d/%0d/%0b", $time,
                 shift_amount, stage, busy, done, m_shift, m_stage, m_done);
      end
    end
    vectors++;
    if (stage !== 3'd3 || shift_amount !== 4'd15 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL sustain_silent got stage=%0d shift=%0d busy=%0b want 3/15/1", stage, shift_amount, busy);
    end
    gate = 1'b0;
    for (int i = 0; i < 10 && stage != 3'd0; i++) cyc();
  endtask

  task automatic test_code_change();
    int n, changes, first_gap;
    logic [3:0] prev;
    attack_value = 4'd3; sustain_value = 4'd12; release_value = 4'd0;
    gate = 1'b1;
    prev = shift_amount; n = 0; changes = 0;
    for (int i = 0; i < 100 && changes < 3; i++) begin
      cyc(); n++;
      vectors++;
      if (shift_amount !== 4'(m_shift) || stage !== 3'(m_stage) || done !== m_done) begin
        miscompares++;
        $display("FAIL code_track t=%0t got %0d/%0d/%0b want %0d/%0d/%0b", $time,
                 shift_amount, stage, done, m_shift, m_stage, m_done);
      end
      if (shift_amount != prev) begin
        changes++;
        if (changes == 1) attack_value = 4'd0;
        if (changes == 2) begin
          vectors++;
          if (n != 8) begin miscompares++; $display("FAIL code_latched_gap got %0d want 8", n); end
        end
        n = 0; prev = shift_amount;
      end
    end
    gate = 1'b0;
    for (int i = 0; i < 60 && stage != 3'd0; i++) cyc();
    gate = 1'b1;
    prev = shift_amount; first_gap = 0;
    for (int i = 0; i < 40 && shift_amount == prev; i++) begin cyc(); first_gap++; end
    vectors++;
    if (first_gap != 3) begin miscompares++; $display("FAIL code_new_entry_gap got %0d want 3", first_gap); end
    gate = 1'b0;
    for (int i = 0; i < 60 && stage != 3'd0; i++) cyc();
  endtask

  task automatic test_reset_mid();
    attack_value = 4'd0; decay_value = 4'd7; sustain_value = 4'd0;
    gate = 1'b1;
    for (int i = 0; i < 80 && stage != 3'd2; i++) cyc();
    for (int i = 0; i < 5; i++) cyc();
    vectors++;
    if (stage !== 3'd2) begin miscompares++; $display("FAIL reset_mid_setup got stage=%0d want 2", stage); end
    reset = 1'b1;
    model_reset();
    #1;
    vectors++;
    if (shift_amount !== 4'd15 || stage !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_async got %0d/%0d/%0b/%0b want 15/0/0/0", shift_amount, stage, busy, done);
    end
    cyc();
    vectors++;
    if (shift_amount !== 4'd15 || stage !== 3'd0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_edge got %0d/%0d/%0b want 15/0/0", shift_amount, stage, done);
    end
    reset = 1'b0; gate = 1'b0;
    cyc();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 24) == 0) gate = ~gate;
      if ($urandom_range(0, 49) == 0) attack_value  = 4'($urandom_range(0, 2));
      if ($urandom_range(0, 49) == 0) decay_value   = 4'($urandom_range(0, 2));
      if ($urandom_range(0, 49) == 0) release_value = 4'($urandom_range(0, 2));
      if ($urandom_range(0, 39) == 0) sustain_value = 4'($urandom_range(0, 15));
      cyc();
      vectors++;
      if (shift_amount !== 4'(m_shift) || stage !== 3'(m_stage) || busy !== (m_stage != 0) || done !== m_done) begin
        miscompares++;
        $display("FAIL random_track t=%0t got %0d/%0d/%0b/%0b want %0d/%0d/%0b", $time,
                 shift_amount, stage, busy, done, m_shift, m_stage, m_done);
      end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    test_reset();
    test_adsr();
    test_release();
    test_retrigger();
    test_sustain_extremes();
    test_code_change();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
